// File: rtl/mux_rr_scheduler_if.sv
// Request/grant/data bundle between the requesters and the round-robin mux scheduler.
// The requester side is the master and the scheduler is the slave.
interface mux_rr_scheduler_if #(
    parameter int NREQ = 8
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] data;
    logic [NREQ-1:0] gnt;
    logic [2:0]      sel;
    logic            busy;
    logic            dout;
    logic            dout_vld;

    modport master (
        output req, data,
        input  gnt, sel, busy, dout, dout_vld
    );

    modport slave (
        input  req, data,
        output gnt, sel, busy, dout, dout_vld
    );
endinterface

// File: rtl/mux_rr_scheduler.sv
// Round-robin owner selection for a shared 8:1 bit-select mux with bounded hold time.
// Registered grant, select and one-cycle-delayed selected data bit with a valid flag.
module mux_rr_scheduler #(
    parameter int NREQ     = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst,
    mux_rr_scheduler_if.slave  bus
);
    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t          r_state, w_state_next;
    logic [2:0]      r_ptr, w_ptr_next;
    logic [2:0]      r_sel, w_sel_next;
    logic [3:0]      r_hcnt, w_hcnt_next;
    logic [NREQ-1:0] r_gnt, w_gnt_next;
    logic            r_busy, w_busy_next;
    logic            r_dout, r_dout_vld;

    logic [NREQ-1:0] w_cand;
    logic [NREQ-1:0] w_rot;
    logic [2:0]      w_start;
    logic [2:0]      w_off;
    logic [2:0]      w_win;
    logic            w_found;

    // In IDLE the search starts at ptr; while granted it starts just past the owner and skips it.
    always_comb begin
        w_cand  = bus.req;
        w_start = r_ptr;
        if (r_state == S_GRANT) begin
            w_cand  = bus.req & ~(NREQ'(1) << r_sel);
            w_start = r_sel + 3'd1;
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
        assign w_rot[gi] = w_cand[w_start + 3'(gi)];
    end

    always_comb begin
        w_found = |w_rot;
        w_off   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = 3'(i);
        end
    end

    assign w_win = w_start + w_off;

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_sel_next   = r_sel;
        w_hcnt_next  = r_hcnt;
        w_gnt_next   = r_gnt;
        w_busy_next  = r_busy;
        case (r_state)
            S_IDLE: begin
                w_gnt_next  = '0;
                w_busy_next = 1'b0;
                if (w_found) begin
                    w_state_next = S_GRANT;
                    w_sel_next   = w_win;
                    w_gnt_next   = NREQ'(1) << w_win;
                    w_busy_next  = 1'b1;
                    w_hcnt_next  = 4'd1;
                end
            end
            S_GRANT: begin
                if (!bus.req[r_sel] || (r_hcnt == 4'(MAX_HOLD) && w_found)) begin
                    // Release or forced rotation: the owner drops to lowest priority.
                    w_ptr_next = r_sel + 3'd1;
                    if (w_found) begin
                        w_sel_next  = w_win;
                        w_gnt_next  = NREQ'(1) << w_win;
                        w_hcnt_next = 4'd1;
                    end else begin
                        w_state_next = S_IDLE;
                        w_gnt_next   = '0;
                        w_busy_next  = 1'b0;
                    end
                end else if (r_hcnt < 4'(MAX_HOLD)) begin
                    w_hcnt_next = r_hcnt + 4'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_gnt_next   = '0;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_sel      <= '0;
            r_hcnt     <= '0;
            r_gnt      <= '0;
            r_busy     <= 1'b0;
            r_dout     <= 1'b0;
            r_dout_vld <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ptr      <= w_ptr_next;
            r_sel      <= w_sel_next;
            r_hcnt     <= w_hcnt_next;
            r_gnt      <= w_gnt_next;
            r_busy     <= w_busy_next;
            r_dout     <= bus.data[r_sel];
            r_dout_vld <= r_busy;
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.sel      = r_sel;
    assign bus.busy     = r_busy;
    assign bus.dout     = r_dout;
    assign bus.dout_vld = r_dout_vld;
endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed plus randomized checks of the round-robin mux scheduler against an
// integer-level arbitration model evaluated once per clock edge.
module tb_mux_rr_scheduler;
    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_rr_scheduler_if #(.NREQ(8)) bus ();

    mux_rr_scheduler #(.NREQ(8), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: owner index or -1 when idle
    int m_owner, m_ptr, m_hcnt, m_sel;
    bit m_dout, m_vld;

    function automatic int search(logic [7:0] r, int start, int excl);
        for (int i = 0; i < 8; i++) begin
            int k;
            k = (start + i) % 8;
            if (k != excl && r[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic r, input logic [7:0] rq, input logic [7:0] d);
        int w;
        if (r) begin
            m_owner = -1; m_ptr = 0; m_hcnt = 0; m_sel = 0; m_dout = 0; m_vld = 0;
            return;
        end
        m_dout = d[m_sel];
        m_vld  = (m_owner >= 0);
        if (m_owner < 0) begin
            w = search(rq, m_ptr, -1);
            if (w >= 0) begin m_owner = w; m_sel = w; m_hcnt = 1; end
        end else if (!rq[m_owner] || (m_hcnt == MAX_HOLD && search(rq, m_owner + 1, m_owner) >= 0)) begin
            m_ptr = (m_owner + 1) % 8;
            w = search(rq, m_ptr, m_owner);
            if (w >= 0) begin m_owner = w; m_sel = w; m_hcnt = 1; end
            else m_owner = -1;
        end else if (m_hcnt < MAX_HOLD) begin
            m_hcnt++;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] d);
        logic [7:0] exp_gnt;
        rst      = r;
        bus.req  = rq;
        bus.data = d;
        @(posedge clk);
        model_edge(r, rq, d);
        #1;
        exp_gnt = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
        $display("t=%0t rst=%0b req=%02h data=%02h -> gnt=%02h sel=%0d busy=%0b dout=%0b vld=%0b",
                 $time, r, rq, d, bus.gnt, bus.sel, bus.busy, bus.dout, bus.dout_vld);
        chk("gnt",      bus.gnt,            exp_gnt);
        chk("sel",      8'(bus.sel),        8'(m_sel));
        chk("busy",     8'(bus.busy),       8'(m_owner >= 0));
        chk("dout_vld", 8'(bus.dout_vld),   8'(m_vld));
        chk("dout",     8'(bus.dout),       8'(m_dout));
    endtask

    initial begin
        logic [7:0] pat;
        int len;
        rst = 1'b1; bus.req = '0; bus.data = '0;

        // Reset with all requests high, then release
        step(1, 8'hFF, 8'h00);
        step(1, 8'hFF, 8'h00);
        chk("reset_gnt_zero", bus.gnt, 8'h00);
        step(0, 8'hFF, 8'h00);
        chk("first_gnt", bus.gnt, 8'h01);
        step(0, 8'h00, 8'h00);
        step(0, 8'h00, 8'h00);

        // Single requester holds indefinitely
        for (int i = 0; i < 10; i++) step(0, 8'h20, 8'h20);
        chk("single_sel", 8'(bus.sel), 8'd5);
        chk("single_dout", 8'(bus.dout), 8'd1);
        step(0, 8'h00, 8'h20);
        chk("single_drop", bus.gnt, 8'h00);
        step(0, 8'h00, 8'h20);

        // Forced rotation between 0 and 7
        for (int i = 0; i < 20; i++) step(0, 8'h81, 8'h00);
        step(0, 8'h00, 8'h00);
        step(0, 8'h00, 8'h00);

        // Release with zero dead cycle, owner 3 then 6 then 1
        step(1, 8'h00, 8'h00);
        step(0, 8'h08, 8'h00);
        step(0, 8'h4A, 8'h00);
        step(0, 8'h42, 8'h00);
        chk("release_to6", bus.gnt, 8'h40);
        step(0, 8'h02, 8'h00);
        chk("wrap_to1", bus.gnt, 8'h02);
        step(0, 8'h00, 8'h00);

        // Data path: grant 1 then 5
        for (int i = 0; i < 3; i++) step(0, 8'h02, 8'h42);
        for (int i = 0; i < 3; i++) step(0, 8'h20, 8'h42);
        step(0, 8'h00, 8'h42);
        step(0, 8'h00, 8'h42);
        chk("vld_low_after_release", 8'(bus.dout_vld), 8'd0);

        // Reset mid-grant
        for (int i = 0; i < 3; i++) step(0, 8'h04, 8'h00);
        step(1, 8'h04, 8'h00);
        chk("midgrant_reset", bus.gnt, 8'h00);
        step(0, 8'h0C, 8'h00);
        chk("after_reset_gnt", bus.gnt, 8'h04);
        for (int i = 0; i < 5; i++) step(0, 8'h0C, 8'h00);

        // Randomized bursts of held request patterns
        for (int b = 0; b < 70; b++) begin
            pat = 8'($urandom);
            if ($urandom_range(0, 1) == 1) pat = pat & 8'($urandom);
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 5) == 0) pat[$urandom_range(0, 7)] ^= 1'b1;
                step(($urandom_range(0, 60) == 0), pat, 8'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mux_rr_scheduler.md
Name: mux_rr_scheduler

Overview:
- Round-robin scheduler that shares the 8:1 bit-select mux among 8 requesters.
- Picks one owner at a time, drives the mux select and a one-hot grant, and returns the selected data bit registered with a valid flag.
- Sits directly in front of the 8:1 mux. Its `sel` output is the mux `S` input. Its `data` input is the same 8-bit vector as the mux `I` input.
- Bounded hold time guarantees fairness under continuous contention.

Parameters:
- NREQ, 8: number of requesters. Fixed at 8 for this revision; `sel` width is 3.
- MAX_HOLD, 4: maximum consecutive grant cycles for one owner while another requester is pending. Legal range 1..15.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  reset, synchronous, active-high.
- req  input  8  per-requester request, level-sensitive.
- data  input  8  mux data vector; bit k belongs to requester k.
- gnt  output  8  one-hot grant, registered; all-zero when idle.
- sel  output  3  mux select (index of current owner), registered.
- busy  output  1  high while any grant is held.
- dout  output  1  registered `data[sel]`, updated while busy.
- dout_vld  output  1  `dout` is valid for the current owner.

Behaviour:
- All outputs are registered, and all decisions are evaluated at the rising edge of `clk` from the current `req`.

Reset (`rst`=1 at an edge, overrides everything):
- `gnt`=0, `sel`=0, `busy`=0, `dout`=0, `dout_vld`=0.
- Internal priority pointer `ptr`=0, hold counter `hcnt`=0, state IDLE.
- Reset mid-grant drops `gnt` at that same edge. There is no completion of a hold.

States:
- IDLE:
  - If `req`==0: stay; `gnt`=0, `busy`=0, `sel` holds its last value.
  - Else grant the winner W and go to GRANT. W is the first k with `req[k]`=1, searching `ptr`, `ptr+1`, ... modulo 8.
  - On grant: `gnt`=1<<W, `sel`=W, `busy`=1, `hcnt`=1.
  - Latency from `req` rising to `gnt`: 1 clock.
- GRANT, with owner O:
  - (a) Release: `req[O]`=0.
    - `ptr` becomes O+1 mod 8.
    - Search the other requesters starting at O+1. If one is found, grant it at this edge (zero dead cycles, `hcnt`=1). Otherwise go to IDLE, `gnt`=0.
  - (b) Forced rotation: `req[O]`=1, `hcnt`==MAX_HOLD, and another `req` bit is set.
    - Rotate exactly as in (a), excluding O from the search.
    - O re-enters arbitration as lowest priority.
  - (c) Otherwise keep O.
    - `hcnt` increments, saturating at MAX_HOLD.
    - If no other requester is pending, O holds indefinitely.
    - When another requester arrives after saturation, rotation occurs at the next edge.
- Search with exactly one other requester yields that requester. With none, the result is IDLE (case a) or keep O (case b cannot fire).
- `ptr` wraps from 7 to 0.
- Simultaneous release by O and new requests: new requests are eligible at that same edge.

Output rules:
- `sel` always equals the index of the set `gnt` bit when `busy`=1.
- `gnt` is never multi-hot.
- `dout`/`dout_vld` (one-cycle pipeline behind `sel`):
  - Each edge: `dout` <= `data[sel_q]` and `dout_vld` <= `busy_q`, using the values `sel` and `busy` had before that edge.
  - So `dout` reflects the owner granted one cycle earlier.
  - `dout_vld` deasserts one cycle after `busy` falls.
- `req` bits for non-owners may toggle freely. No request is ever lost while it is held high, and worst-case wait is 7*MAX_HOLD+1 cycles.

Test Plan:
- Reset: hold `rst`=1 with `req`=8'hFF for 2 cycles -> `gnt`=0, `sel`=0, `busy`=0, `dout_vld`=0. Release `rst` -> next edge `gnt`=8'h01, `sel`=0.
- Single requester: `req`=8'b0010_0000 held 10 cycles, `data`=8'b0010_0000 -> `gnt`=8'h20, `sel`=5 continuously (no rotation), `dout`=1 with `dout_vld`=1 from 2nd cycle. Drop `req` -> `gnt`=0 next edge.
- Forced rotation, MAX_HOLD=4: `req`=8'h81 held -> `gnt` 8'h01 for 4 cycles, then 8'h80 for 4, then 8'h01. Pattern repeats with no idle gap.
- Release with zero dead cycle: owner 3 drops `req` while `req[6]`,`req[1]` are set -> next `gnt`=8'h40 (search from 4), `sel`=6. After 6 releases -> `gnt`=8'h02 (wrap).
- Data path: `data`=8'b0100_0010, grant 1 then 5 -> `dout`=1 one cycle after `sel`=1, `dout`=0 one cycle after `sel`=5. `dout_vld` low one cycle after last release.
- Reset mid-grant: owner 2 at `hcnt`=3, assert `rst` one cycle -> `gnt`=0 at that edge. With `req`=8'h0C after reset -> `gnt`=8'h04 (`ptr`=0), `hcnt` restarts at 1.
